signal_gen_multi: RTL and testbench
===================================

// Module: signal_gen_multi
// PURPOSE
//  Parametrised multi-voice successor to the single-channel signal generator. NUM_CH
//  phase-accumulator voices (square/pulse/noise/ramp, 4-bit volume) are summed and
//  PWM-encoded onto one output pin. Sits in the top level, written via pin-driven
//  strobe/addr/data; voices advance on tick_en from the clock scaler (no derived clock).
// PARAMETERS
//  NUM_CH   4   number of voices (power of 2, 1..8)
//  ACC_W    16  phase accumulator / frequency word width (>=8, even)
//  ADDR_W   clog2(NUM_CH)+2   derived, do not override
//  MIX_W    4+clog2(NUM_CH)   derived mix/PWM width
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  tick_en    in   1       1-clk voice advance enable from clock scaler
//  wr_strobe  in   1       register write strobe, asynchronous pin
//  wr_addr    in   ADDR_W  {channel, reg[1:0]}
//  wr_data    in   8       write data
//  audio_out  out  1       PWM mixed output
//  ch_active  out  NUM_CH  per-voice instantaneous output level != 0
//  mix_level  out  MIX_W   latched mix value driving the current PWM frame
// BEHAVIOUR
//  Reset (async assert, sync release): all regs, accumulators, shadows, PWM state = 0;
//   LFSR[ch] = 15'h0001 + ch; audio_out=0, ch_active=0, mix_level=0.
//  Write path: wr_strobe -> 2-flop sync -> rising-edge detect -> one write per rising
//   edge; addr/data sampled at the edge-detect cycle (pins held stable by host). Write
//   visible in register 3 clk edges after strobe first sampled high.
//  Reg map per channel: 0 freq_lo -> shadow only; 1 freq_hi -> freq = {data, shadow}
//   committed atomically (bits above ACC_W discarded); 2 ctrl: [1:0] mode, [2] enable,
//   [3] phase_reset (self-clearing, not stored), [7:4] volume; 3 reserved, write ignored.
//  Voice, on tick_en && enable: acc <= acc + freq (mod 2^ACC_W); carry out steps the LFSR
//   (x^15+x^14+1, shift left). enable=0: acc held at 0, amplitude 0, LFSR holds.
//  phase_reset write clears acc same cycle as the ctrl update; wins over a coincident tick.
//  Write and tick in same cycle: tick uses old freq/ctrl; new value used from next tick.
//  Amplitude (4b): mode0 square = acc[MSB]?vol:0; mode1 pulse25 = acc[MSB:MSB-1]==2'b11?
//   vol:0; mode2 noise = lfsr[0]?vol:0; mode3 ramp = (acc[MSB:MSB-3]*vol)>>4.
//  Mix: unsigned sum of amplitudes, MIX_W bits, cannot overflow (max 15*NUM_CH).
//  PWM: free-running MIX_W-bit counter on clk; mix_level latched when counter == all-ones
//   (frame boundary, glitch-free); audio_out = (cnt < mix_level), registered, 1 clk
//   latency. Full scale never 100% duty; mix 0 -> constant 0.
//  ch_active[i] = amplitude[i] != 0, registered.
//  Reset mid-frame/mid-write: everything returns to reset values; pending sync edge lost.
// STRUCTURE
//  Package sig_gen_pkg: mode encodings (MODE_SQUARE..MODE_RAMP), REG_* offsets, ctrl
//   bit positions, LFSR taps/seed base.
//  Sub-module sig_voice (one per channel, generate loop): regs, shadow, acc, LFSR, amp.
//  Top: strobe sync/edge detect, address decode, adder tree, PWM.
// TESTING
//  Reset: rst_n low mid-activity -> all outputs 0 immediately; LFSR[2]=15'h0003 after.
//  Write ch1 freq_lo=8'h00, freq_hi=8'h40, ctrl=8'hF4 (square, vol15); tick_en every clk
//   -> acc[MSB] toggles every 2 ticks, ch_active[1] period 4 ticks, mix 15/0.
//  Atomicity: freq_lo=8'hFF alone -> voice freq unchanged until freq_hi written.
//  Mix: all 4 voices square vol 15 in phase -> mix_level=60, audio_out high 60 of 64 clks.
//  Noise: ch0 mode2 freq 16'hFFFF -> LFSR steps nearly every tick; sequence matches model.
//  Strobe held high 10 clks -> exactly one write; ctrl bit3 with tick -> acc=0 next clk.

Source files
------------

// File: rtl/signal_gen_multi_pkg.sv
// Shared encodings for the multi-voice signal generator: voice modes, register
// offsets, ctrl byte layout and the noise LFSR definition.
package sig_gen_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_PULSE  = 2'd1,
        MODE_NOISE  = 2'd2,
        MODE_RAMP   = 2'd3
    } mode_e;

    localparam logic [1:0] REG_FREQ_LO = 2'd0;
    localparam logic [1:0] REG_FREQ_HI = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;

    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_EN_BIT   = 2;
    localparam int CTRL_PR_BIT   = 3;
    localparam int CTRL_VOL_LSB  = 4;

    // x^15 + x^14 + 1, shifting left; voice n is seeded with SEED_BASE + n
    localparam int              LFSR_W         = 15;
    localparam int              LFSR_TAP_A     = 14;
    localparam int              LFSR_TAP_B     = 13;
    localparam logic [14:0]     LFSR_SEED_BASE = 15'h0001;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
    endfunction

endpackage

// File: rtl/signal_gen_multi_if.sv
// Host-side register write bus (strobe/addr/data pins) of the signal generator.
interface signal_gen_multi_if #(
    parameter int NUM_CH = 4
);
    localparam int ADDR_W = $clog2(NUM_CH) + 2;

    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (output wr_strobe, wr_addr, wr_data);
    modport slave  (input  wr_strobe, wr_addr, wr_data);
endinterface

// File: rtl/signal_gen_multi_voice.sv
// One generator voice: register file, frequency shadow, phase accumulator,
// noise LFSR and the 4-bit amplitude selected by mode and volume.
module sig_voice
    import sig_gen_pkg::*;
#(
    parameter int ACC_W  = 16,
    parameter int CH_IDX = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_en,
    input  logic       we,
    input  logic [1:0] reg_sel,
    input  logic [7:0] wdata,
    output logic [3:0] amp
);
    logic [ACC_W-1:0]  freq;
    logic [ACC_W-1:0]  acc;
    logic [7:0]        shadow;
    mode_e             mode;
    logic              en;
    logic [3:0]        vol;
    logic [LFSR_W-1:0] lfsr;
    logic [ACC_W:0]    acc_sum;
    logic [15:0]       freq_new;
    logic [7:0]        ramp_prod;
    logic              phase_rst;

    assign acc_sum   = {1'b0, acc} + {1'b0, freq};
    assign freq_new  = {wdata, shadow};
    assign phase_rst = we && (reg_sel == REG_CTRL) && wdata[CTRL_PR_BIT];

    // freq only changes on the high-byte write, so the 16-bit update is atomic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            freq   <= '0;
            mode   <= MODE_SQUARE;
            en     <= 1'b0;
            vol    <= '0;
        end else if (we) begin
            case (reg_sel)
                REG_FREQ_LO: shadow <= wdata;
                REG_FREQ_HI: freq   <= ACC_W'(freq_new);
                REG_CTRL: begin
                    mode <= mode_e'(wdata[CTRL_MODE_LSB +: 2]);
                    en   <= wdata[CTRL_EN_BIT];
                    vol  <= wdata[CTRL_VOL_LSB +: 4];
                end
                default: ;
            endcase
        end
    end

    // Phase reset cancels a coincident tick entirely (no accumulate, no LFSR step)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            lfsr <= LFSR_SEED_BASE + LFSR_W'(CH_IDX);
        end else if (phase_rst || !en) begin
            acc <= '0;
        end else if (tick_en) begin
            acc <= acc_sum[ACC_W-1:0];
            if (acc_sum[ACC_W]) lfsr <= lfsr_next(lfsr);
        end
    end

    assign ramp_prod = {4'b0, acc[ACC_W-1 -: 4]} * {4'b0, vol};

    always_comb begin
        amp = '0;
        if (en) begin
            case (mode)
                MODE_SQUARE: amp = acc[ACC_W-1] ? vol : 4'd0;
                MODE_PULSE:  amp = (acc[ACC_W-1 -: 2] == 2'b11) ? vol : 4'd0;
                MODE_NOISE:  amp = lfsr[0] ? vol : 4'd0;
                MODE_RAMP:   amp = ramp_prod[7:4];
                default:     amp = '0;
            endcase
        end
    end

endmodule

// File: rtl/signal_gen_multi.sv
// Multi-voice signal generator top: strobe synchroniser and decode, voice array,
// amplitude mixer and frame-latched PWM output.
module signal_gen_multi
    import sig_gen_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int ACC_W  = 16,
    localparam int ADDR_W = $clog2(NUM_CH) + 2,
    localparam int MIX_W  = 4 + $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_en,
    signal_gen_multi_if.slave   bus,
    output logic                audio_out,
    output logic [NUM_CH-1:0]   ch_active,
    output logic [MIX_W-1:0]    mix_level
);
    logic [2:0]              strb_sync;
    logic                    wr_pulse;
    logic [NUM_CH-1:0][3:0]  amp;
    logic [MIX_W-1:0]        mix_sum;
    logic [MIX_W-1:0]        pwm_cnt;

    // Two flops for the asynchronous pin, a third for rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) strb_sync <= '0;
        else        strb_sync <= {strb_sync[1:0], bus.wr_strobe};
    end

    assign wr_pulse = strb_sync[1] & ~strb_sync[2];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we;
        assign we = wr_pulse && (ADDR_W'(bus.wr_addr >> 2) == ADDR_W'(i));

        sig_voice #(.ACC_W(ACC_W), .CH_IDX(i)) u_voice (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick_en (tick_en),
            .we      (we),
            .reg_sel (bus.wr_addr[1:0]),
            .wdata   (bus.wr_data),
            .amp     (amp[i])
        );
    end

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_CH; i++) mix_sum = mix_sum + MIX_W'(amp[i]);
    end

    // mix_level only moves at the frame boundary so a PWM frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt   <= '0;
            mix_level <= '0;
            audio_out <= 1'b0;
            ch_active <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + MIX_W'(1);
            if (&pwm_cnt) mix_level <= mix_sum;
            audio_out <= (pwm_cnt < mix_level);
            for (int i = 0; i < NUM_CH; i++) ch_active[i] <= |amp[i];
        end
    end

endmodule

// File: tb/tb_signal_gen_multi.sv
// Bench for signal_gen_multi: randomised writes/ticks against a behavioural
// model of voices, write timing and PWM framing.
module tb_signal_gen_multi;
    localparam int NUM_CH  = 4;
    localparam int ACC_W   = 16;
    localparam int MIX_W   = 6;
    localparam int ACC_MOD = 1 << ACC_W;
    localparam int FRAME   = 1 << MIX_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tick_en = 1'b0;
    logic              audio_out;
    logic [NUM_CH-1:0] ch_active;
    logic [MIX_W-1:0]  mix_level;

    signal_gen_multi_if #(.NUM_CH(NUM_CH)) bus ();

    signal_gen_multi #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_en   (tick_en),
        .bus       (bus),
        .audio_out (audio_out),
        .ch_active (ch_active),
        .mix_level (mix_level)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    int m_acc[NUM_CH], m_freq[NUM_CH], m_shadow[NUM_CH];
    int m_mode[NUM_CH], m_en[NUM_CH], m_vol[NUM_CH], m_lfsr[NUM_CH];
    int m_cnt, m_mix, m_pend;
    logic m_prev;
    logic [NUM_CH-1:0] exp_active;
    logic [MIX_W-1:0]  exp_mix;
    logic              exp_audio;

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_acc[c] = 0; m_freq[c] = 0; m_shadow[c] = 0;
            m_mode[c] = 0; m_en[c] = 0; m_vol[c] = 0;
            m_lfsr[c] = 1 + c;
        end
        m_cnt = 0; m_mix = 0; m_pend = 0; m_prev = 1'b0;
        exp_active = '0; exp_mix = '0; exp_audio = 1'b0;
    endfunction

    function automatic int amp_of(int c);
        int top4;
        top4 = m_acc[c] / (ACC_MOD / 16);
        if (m_en[c] == 0) return 0;
        case (m_mode[c])
            0:       return (top4 >= 8)  ? m_vol[c] : 0;
            1:       return (top4 >= 12) ? m_vol[c] : 0;
            2:       return (m_lfsr[c] % 2 == 1) ? m_vol[c] : 0;
            default: return (top4 * m_vol[c]) / 16;
        endcase
    endfunction

    // Advance the model across one clock edge with the inputs present at that edge
    function automatic void model_edge(input logic tk);
        int sum, a, wch, wreg, d, s, fb;
        logic do_wr, pr;
        sum = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            a = amp_of(c);
            sum += a;
            exp_active[c] = (a != 0);
        end
        exp_audio = (m_cnt < m_mix);
        if (m_cnt == FRAME - 1) m_mix = sum;
        m_cnt = (m_cnt + 1) % FRAME;
        exp_mix = MIX_W'(m_mix);

        do_wr = (m_pend == 1);
        if (m_pend > 0) m_pend--;
        if (bus.wr_strobe && !m_prev) m_pend = 2;
        m_prev = bus.wr_strobe;
        wch  = int'(bus.wr_addr) / 4;
        wreg = int'(bus.wr_addr) % 4;
        d    = int'(bus.wr_data);
        pr   = do_wr && (wreg == 2) && ((d / 8) % 2 == 1);

        for (int c = 0; c < NUM_CH; c++) begin
            if ((pr && c == wch) || m_en[c] == 0) begin
                m_acc[c] = 0;
            end else if (tk) begin
                s = m_acc[c] + m_freq[c];
                if (s >= ACC_MOD) begin
                    fb = ((m_lfsr[c] / 16384) + (m_lfsr[c] / 8192)) % 2;
                    m_lfsr[c] = (m_lfsr[c] * 2 + fb) % 32768;
                end
                m_acc[c] = s % ACC_MOD;
            end
        end
        if (do_wr) begin
            case (wreg)
                0: m_shadow[wch] = d;
                1: m_freq[wch] = (d * 256 + m_shadow[wch]) % ACC_MOD;
                2: begin
                    m_mode[wch] = d % 4;
                    m_en[wch]   = (d / 4) % 2;
                    m_vol[wch]  = d / 16;
                end
                default: ;
            endcase
        end
    endfunction

    // tk: 0 = no tick, 1 = tick, 2 = random
    task automatic step(input int tk);
        logic t;
        t = (tk == 2) ? ($urandom_range(0, 1) == 1) : (tk != 0);
        tick_en = t;
        @(posedge clk);
        model_edge(t);
        #1;
    endtask

    task automatic do_write(input int ch, input int r, input int d, input int tk, input int hold);
        bus.wr_addr   = 4'(ch * 4 + r);
        bus.wr_data   = 8'(d);
        bus.wr_strobe = 1'b1;
        repeat (hold) step(tk);
        bus.wr_strobe = 1'b0;
        repeat (3) step(tk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick_en = 1'b0;
        bus.wr_strobe = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.wr_strobe = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (audio_out !== 1'b0) begin n_fail++; $display("FAIL reset audio_out got %b exp 0", audio_out); end
        n_chk++; if (ch_active !== '0) begin n_fail++; $display("FAIL reset ch_active got %b exp 0", ch_active); end
        n_chk++; if (mix_level !== '0) begin n_fail++; $display("FAIL reset mix_level got %0d exp 0", mix_level); end
        rst_n = 1'b1;
        for (int k = 0; k < 70; k++) begin
            step(2);
            n_chk++;
            if ({ch_active, mix_level, audio_out} !== {exp_active, exp_mix, exp_audio}) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d got %b/%0d/%b exp %b/%0d/%b", k, ch_active, mix_level, audio_out, exp_active, exp_mix, exp_audio);
            end
        end
    endtask

    task automatic test_square();
        int ones;
        do_write(1, 0, 8'h00, 1, 1);
        do_write(1, 1, 8'h40, 1, 1);
        do_write(1, 2, 8'hF4, 1, 1);
        ones = 0;
        for (int k = 0; k < 80; k++) begin
            step(1);
            if (k >= 40 && k < 56) ones += int'(ch_active[1]);
            n_chk++;
            if ({ch_active, mix_level, audio_out} !== {exp_active, exp_mix, exp_audio}) begin
                n_fail++;
                $display("FAIL square cyc %0d got %b/%0d/%b exp %b/%0d/%b", k, ch_active, mix_level, audio_out, exp_active, exp_mix, exp_audio);
            end
        end
        n_chk++;
        if (ones != 8) begin n_fail++; $display("FAIL square_duty ch_active[1] high %0d of 16 exp 8", ones); end
    endtask

    task automatic test_atomic();
        do_write(1, 0, 8'hFF, 2, 1);
        for (int k = 0; k < 40; k++) begin
            step(2);
            n_chk++;
            if ({ch_active, mix_level, audio_out} !== {exp_active, exp_mix, exp_audio}) begin
                n_fail++;
                $display("FAIL atomic_lo cyc %0d got %b/%0d/%b exp %b/%0d/%b", k, ch_active, mix_level, audio_out, exp_active, exp_mix, exp_audio);
            end
        end
        do_write(1, 1, 8'h40, 2, 1);
        for (int k = 0; k < 40; k++) begin
            step(2);
            n_chk++;
            if ({ch_active, mix_level, audio_out} !== {exp_active, exp_mix, exp_audio}) begin
                n_fail++;
                $display("FAIL atomic_hi cyc %0d got %b/%0d/%b exp %b/%0d/%b", k, ch_active, mix_level, audio_out, exp_active, exp_mix, exp_audio);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            step(1);
            seen = (exp_mix != 0);
            n_chk++;
            if ({ch_active, mix_level, audio_out} !== {exp_active, exp_mix, exp_audio}) begin
                n_fail++;
                $display("FAIL pre_reset cyc %0d got %b/%0d/%b exp %b/%0d/%b", k, ch_active, mix_level, audio_out, exp_active, exp_mix, exp_audio);
            end
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL pre_reset_timeout mix never nonzero got %0d exp >0", exp_mix); end
        // Start a write to ch0 (noise, vol 15) and reset before it lands
        bus.wr_addr = 4'(0 * 4 + 2); bus.wr_data = 8'hF6; bus.wr_strobe = 1'b1;
        step(1);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({ch_active, mix_level, audio_out} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset outputs got %b/%0d/%b exp 0/0/0", ch_active, mix_level, audio_out);
        end
        bus.wr_strobe = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            n_chk++;
            if ({ch_active, mix_level, audio_out} !== {exp_active, exp_mix, exp_audio}) begin
                n_fail++;
                $display("FAIL lost_write cyc %0d got %b/%0d/%b exp %b/%0d/%b", k, ch_active, mix_level, audio_out, exp_active, exp_mix, exp_audio);
            end
        end
    endtask

    task automatic test_noise();
        for (int c = 0; c <= 2; c += 2) begin
            do_write(c, 0, 8'hFF, 0, 1);
            do_write(c, 1, 8'hFF, 0, 1);
            do_write(c, 2, 8'hF6, 0, 1);
        end
        step(0);
        n_chk++;
        if (ch_active[2] !== 1'b1) begin n_fail++; $display("FAIL noise_seed ch_active[2] got %b exp 1", ch_active[2]); end
        for (int k = 0; k < 300; k++) begin
            step(k % 17 == 0 ? 0 : 1);
            n_chk++;
            if ({ch_active, mix_level, audio_out} !== {exp_active, exp_mix, exp_audio}) begin
                n_fail++;
                $display("FAIL noise cyc %0d got %b/%0d/%b exp %b/%0d/%b", k, ch_active, mix_level, audio_out, exp_active, exp_mix, exp_audio);
            end
        end
    endtask

    task automatic test_mix();
        int highs;
        apply_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            do_write(c, 0, 8'h00, 0, 1);
            do_write(c, 1, 8'h80, 0, 1);
            do_write(c, 2, 8'hF4, 0, 1);
        end
        step(1);
        for (int k = 0; k < 140; k++) begin
            step(0);
            n_chk++;
            if ({ch_active, mix_level, audio_out} !== {exp_active, exp_mix, exp_audio}) begin
                n_fail++;
                $display("FAIL mix cyc %0d got %b/%0d/%b exp %b/%0d/%b", k, ch_active, mix_level, audio_out, exp_active, exp_mix, exp_audio);
            end
        end
        n_chk++;
        if (mix_level !== 6'd60) begin n_fail++; $display("FAIL mix_level got %0d exp 60", mix_level); end
        highs = 0;
        for (int k = 0; k < FRAME; k++) begin
            step(0);
            highs += int'(audio_out);
        end
        n_chk++;
        if (highs != 60) begin n_fail++; $display("FAIL pwm_duty audio_out high %0d of 64 exp 60", highs); end
    endtask

    task automatic test_strobe_hold();
        do_write(3, 0, 8'h00, 0, 1);
        do_write(3, 1, 8'h40, 0, 1);
        do_write(3, 2, 8'hF4, 1, 1);
        repeat (5) step(2);
        do_write(3, 2, 8'hFC, 1, 10);
        for (int k = 0; k < 30; k++) begin
            step(1);
            n_chk++;
            if ({ch_active, mix_level, audio_out} !== {exp_active, exp_mix, exp_audio}) begin
                n_fail++;
                $display("FAIL strobe_hold cyc %0d got %b/%0d/%b exp %b/%0d/%b", k, ch_active, mix_level, audio_out, exp_active, exp_mix, exp_audio);
            end
        end
    endtask

    task automatic test_random();
        int idle;
        for (int w = 0; w < 60; w++) begin
            do_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255), 2, $urandom_range(1, 4));
            idle = $urandom_range(0, 30);
            for (int k = 0; k < idle; k++) begin
                step(2);
                n_chk++;
                if ({ch_active, mix_level, audio_out} !== {exp_active, exp_mix, exp_audio}) begin
                    n_fail++;
                    $display("FAIL random w%0d cyc %0d got %b/%0d/%b exp %b/%0d/%b", w, k, ch_active, mix_level, audio_out, exp_active, exp_mix, exp_audio);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_atomic();
        test_reset_mid();
        test_noise();
        test_strobe_hold();
        test_mix();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
